// File: rtl/ex_alu_unit.sv
// ex_alu_unit -- execute-stage datapath for the 64-bit LEGv8-style pipeline.
//
// Decodes the ALU operation from alu_op and the instruction opcode field,
// selects operand B (register or immediate), runs the ALU and computes the
// branch target old_pc + (imm << SHIFT). Every output is registered once and
// feeds the EX/MEM boundary one cycle after the inputs are sampled.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   in_valid           EX-stage inputs valid; out_valid is its registered copy
//   alu_op             {ALUOp1, ALUOp0} from the control unit
//   instruction_part   instruction[31:21]
//   alu_src            0: B = reg_data_2, 1: B = imm
//   reg_data_1         operand A
//   reg_data_2, imm    operand B candidates (imm is sign-extended)
//   old_pc             PC of the instruction
//   alu_result, zero   registered result and (result == 0)
//   branch_target      registered old_pc + (imm << SHIFT), wrapping
//   alu_opcode         registered decoded 4-bit operation code
//   illegal_op         registered: alu_op = 1x with an unrecognised opcode
//
// Optional feature (macro ALU_FLAGS_EN): adds registered carry and overflow
// outputs for add/sub. Without the macro those ports and their logic are absent.

module ex_alu_unit #(
  parameter int WIDTH = 64,
  parameter int SHIFT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      instruction_part,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] reg_data_1,
  input  logic [WIDTH-1:0] reg_data_2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] old_pc,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] branch_target,
  output logic [3:0]       alu_opcode,
  output logic             illegal_op
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow
`endif
);

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  logic [3:0]       alu_opcode_d, alu_opcode_q;
  logic             illegal_op_d, illegal_op_q;
  logic [WIDTH-1:0] alu_result_d, alu_result_q;
  logic             zero_d, zero_q;
  logic [WIDTH-1:0] branch_target_d, branch_target_q;
  logic             out_valid_d, out_valid_q;

  logic [WIDTH-1:0] op_a, op_b, imm_sh;
  // One extra bit so the carry-out / borrow falls out of the same adder.
  logic [WIDTH:0]   sum, diff;

`ifdef ALU_FLAGS_EN
  logic carry_d, carry_q;
  logic overflow_d, overflow_q;
`endif

  // ALU control decode.
  always_comb begin
    alu_opcode_d = 4'b0010;
    illegal_op_d = 1'b0;
    if (alu_op[1]) begin
      case (instruction_part)
        OPC_ADD: alu_opcode_d = 4'b0010;
        OPC_SUB: alu_opcode_d = 4'b0110;
        OPC_AND: alu_opcode_d = 4'b0000;
        OPC_ORR: alu_opcode_d = 4'b0001;
        default: begin
          alu_opcode_d = 4'b1111;
          illegal_op_d = 1'b1;
        end
      endcase
    end else if (alu_op[0]) begin
      alu_opcode_d = 4'b0111;
    end
  end

  // Operand select, ALU and branch-target adder.
  always_comb begin
    op_a = reg_data_1;
    op_b = alu_src ? imm : reg_data_2;
    sum  = {1'b0, op_a} + {1'b0, op_b};
    diff = {1'b0, op_a} - {1'b0, op_b};

    alu_result_d = '0;
`ifdef ALU_FLAGS_EN
    carry_d    = 1'b0;
    overflow_d = 1'b0;
`endif
    case (alu_opcode_d)
      4'b0000: alu_result_d = op_a & op_b;
      4'b0001: alu_result_d = op_a | op_b;
      4'b0010: begin
        alu_result_d = sum[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
        carry_d    = sum[WIDTH];
        overflow_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                     (sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
      end
      4'b0110: begin
        alu_result_d = diff[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
        // diff[WIDTH] is the borrow; carry is reported as NOT borrow.
        carry_d    = ~diff[WIDTH];
        overflow_d = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                     (diff[WIDTH-1] != op_a[WIDTH-1]);
`endif
      end
      4'b0111: alu_result_d = op_b;
      4'b1100: alu_result_d = ~(op_a | op_b);
      default: alu_result_d = '0;
    endcase

    zero_d = (alu_result_d == '0);

    // Shift drops the upper SHIFT bits of imm; the add wraps modulo 2^WIDTH.
    imm_sh          = imm << SHIFT;
    branch_target_d = old_pc + imm_sh;
    out_valid_d     = in_valid;
  end

  // Registers load every cycle; out_valid only qualifies the payload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q     <= 1'b0;
      alu_result_q    <= '0;
      zero_q          <= 1'b0;
      branch_target_q <= '0;
      alu_opcode_q    <= '0;
      illegal_op_q    <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      alu_result_q    <= alu_result_d;
      zero_q          <= zero_d;
      branch_target_q <= branch_target_d;
      alu_opcode_q    <= alu_opcode_d;
      illegal_op_q    <= illegal_op_d;
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign carry    = carry_q;
  assign overflow = overflow_q;
`endif

  assign out_valid     = out_valid_q;
  assign alu_result    = alu_result_q;
  assign zero          = zero_q;
  assign branch_target = branch_target_q;
  assign alu_opcode    = alu_opcode_q;
  assign illegal_op    = illegal_op_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Bench for ex_alu_unit: table of vectors with constant expectations, a few
// random ADD/SUB/AND/ORR vectors, and hand-written reset sequences.
module tb_ex_alu_unit;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_BAD = 11'b11111111111;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [10:0] instruction_part;
  logic        alu_src;
  logic [63:0] reg_data_1, reg_data_2, imm, old_pc;
  logic        out_valid, zero, illegal_op;
  logic [63:0] alu_result, branch_target;
  logic [3:0]  alu_opcode;
`ifdef ALU_FLAGS_EN
  logic        carry, overflow;
`endif

  ex_alu_unit #(.WIDTH(64), .SHIFT(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
    .instruction_part(instruction_part), .alu_src(alu_src),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .imm(imm),
    .old_pc(old_pc), .out_valid(out_valid), .alu_result(alu_result),
    .zero(zero), .branch_target(branch_target), .alu_opcode(alu_opcode),
    .illegal_op(illegal_op)
`ifdef ALU_FLAGS_EN
    , .carry(carry), .overflow(overflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic [1:0]  op;
    logic [10:0] instr;
    logic        src;
    logic [63:0] a, b, imm, pc;
    logic [63:0] e_res;
    logic        e_zero;
    logic [3:0]  e_opc;
    logic        e_ill;
    logic [63:0] e_tgt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic vld, logic [1:0] op, logic [10:0] instr,
                              logic src, logic [63:0] a, logic [63:0] b,
                              logic [63:0] im, logic [63:0] pc,
                              logic [63:0] e_res, logic e_zero,
                              logic [3:0] e_opc, logic e_ill, logic [63:0] e_tgt);
    vec_t v;
    v.vld = vld; v.op = op; v.instr = instr; v.src = src;
    v.a = a; v.b = b; v.imm = im; v.pc = pc;
    v.e_res = e_res; v.e_zero = e_zero; v.e_opc = e_opc;
    v.e_ill = e_ill; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    in_valid = v.vld; alu_op = v.op; instruction_part = v.instr;
    alu_src = v.src; reg_data_1 = v.a; reg_data_2 = v.b;
    imm = v.imm; old_pc = v.pc;
  endtask

  // Drive on the falling edge, push the expectation, check 1 ns after the
  // capturing rising edge.
  task automatic apply(vec_t v, string nm);
    vec_t e;
    @(negedge clock);
    drive(v);
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk({nm, ".out_valid"},  {63'd0, out_valid},  {63'd0, e.vld});
    chk({nm, ".result"},     alu_result,          e.e_res);
    chk({nm, ".zero"},       {63'd0, zero},       {63'd0, e.e_zero});
    chk({nm, ".opcode"},     {60'd0, alu_opcode}, {60'd0, e.e_opc});
    chk({nm, ".illegal"},    {63'd0, illegal_op}, {63'd0, e.e_ill});
    chk({nm, ".target"},     branch_target,       e.e_tgt);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, ".out_valid"}, {63'd0, out_valid},  64'd0);
    chk({nm, ".result"},    alu_result,          64'd0);
    chk({nm, ".zero"},      {63'd0, zero},       64'd0);
    chk({nm, ".target"},    branch_target,       64'd0);
    chk({nm, ".opcode"},    {60'd0, alu_opcode}, 64'd0);
    chk({nm, ".illegal"},   {63'd0, illegal_op}, 64'd0);
`ifdef ALU_FLAGS_EN
    chk({nm, ".carry"},     {63'd0, carry},      64'd0);
    chk({nm, ".overflow"},  {63'd0, overflow},   64'd0);
`endif
  endtask

  initial begin
    vec_t v;
    logic [63:0] ones;
    ones = '1;

    // vld op    instr   src a                   b                   imm                 pc        res                 z  opc    ill tgt
    vecs.push_back(mk(1, 2'b10, OP_ADD, 0, 64'd5,              64'd7,              64'd0,              64'h1000, 64'd12,             0, 4'b0010, 0, 64'h1000));
    vecs.push_back(mk(1, 2'b10, OP_SUB, 0, 64'h1234,           64'h1234,           64'd0,              64'd0,    64'd0,              1, 4'b0110, 0, 64'd0));
    vecs.push_back(mk(1, 2'b10, OP_SUB, 0, 64'd0,              64'd1,              64'd0,              64'd0,    ones,               0, 4'b0110, 0, 64'd0));
    vecs.push_back(mk(1, 2'b10, OP_AND, 0, 64'hF0F0,           64'hFF00,           64'd0,              64'd0,    64'hF000,           0, 4'b0000, 0, 64'd0));
    vecs.push_back(mk(1, 2'b10, OP_ORR, 0, 64'hF0F0,           64'hFF00,           64'd0,              64'd0,    64'hFFF0,           0, 4'b0001, 0, 64'd0));
    vecs.push_back(mk(1, 2'b10, OP_BAD, 0, 64'd9,              64'd4,              64'd0,              64'd0,    64'd0,              1, 4'b1111, 1, 64'd0));
    vecs.push_back(mk(1, 2'b00, OP_BAD, 1, 64'h100,            64'd77,             64'h18,             64'd0,    64'h118,            0, 4'b0010, 0, 64'h60));
    vecs.push_back(mk(1, 2'b01, OP_ADD, 0, 64'd5,              64'd0,              64'd0,              64'd0,    64'd0,              1, 4'b0111, 0, 64'd0));
    vecs.push_back(mk(1, 2'b01, OP_SUB, 0, 64'd5,              64'd3,              64'd0,              64'd0,    64'd3,              0, 4'b0111, 0, 64'd0));
    vecs.push_back(mk(1, 2'b11, OP_ADD, 0, 64'd1,              64'd2,              64'd0,              64'd0,    64'd3,              0, 4'b0010, 0, 64'd0));
    vecs.push_back(mk(1, 2'b00, OP_ADD, 0, 64'd0,              64'd0,              64'd3,              64'h40,   64'd0,              1, 4'b0010, 0, 64'h4C));
    vecs.push_back(mk(1, 2'b00, OP_ADD, 0, 64'd1,              64'd1,              64'hFFFF_FFFF_FFFF_FFFE, 64'h40, 64'd2,          0, 4'b0010, 0, 64'h38));
    vecs.push_back(mk(1, 2'b00, OP_ADD, 1, 64'd10,             64'd0,              64'hFFFF_FFFF_FFFF_FFFE, 64'd0,  64'd8,          0, 4'b0010, 0, 64'hFFFF_FFFF_FFFF_FFF8));
    vecs.push_back(mk(1, 2'b00, OP_ADD, 0, 64'd0,              64'd0,              64'hC000_0000_0000_0001, 64'd0,  64'd0,          1, 4'b0010, 0, 64'd4));
    vecs.push_back(mk(1, 2'b10, OP_ADD, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,         64'd0,              64'd0,    64'd1,              0, 4'b0010, 0, 64'd0));
    vecs.push_back(mk(1, 2'b01, OP_ADD, 1, 64'd9,              64'd0,              64'd5,              64'd0,    64'd5,              0, 4'b0111, 0, 64'h14));
    vecs.push_back(mk(0, 2'b10, OP_ORR, 0, 64'h1,              64'h2,              64'd0,              64'h8,    64'h3,              0, 4'b0001, 0, 64'h8));

    // Reset at t=0 with random inputs.
    reset = 1'b0;
    in_valid = 1'b1; alu_op = 2'($urandom); instruction_part = 11'($urandom);
    alu_src = 1'($urandom);
    reg_data_1 = {$urandom, $urandom}; reg_data_2 = {$urandom, $urandom};
    imm = {$urandom, $urandom}; old_pc = {$urandom, $urandom};
    #2 chk_all_zero("reset_t0");
    @(posedge clock); #1 chk_all_zero("reset_held");
    @(negedge clock); reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Random register-form vectors against a simple reference.
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  sel;
      logic [63:0] a, b, r, im, pc;
      logic [10:0] ins;
      logic [3:0]  opc;
      sel = 2'($urandom);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      im = {$urandom, $urandom}; pc = {$urandom, $urandom};
      case (sel)
        2'd0: begin ins = OP_ADD; r = a + b; opc = 4'b0010; end
        2'd1: begin ins = OP_SUB; r = a - b; opc = 4'b0110; end
        2'd2: begin ins = OP_AND; r = a & b; opc = 4'b0000; end
        default: begin ins = OP_ORR; r = a | b; opc = 4'b0001; end
      endcase
      v = mk(1, 2'b10, ins, 0, a, b, im, pc, r, (r == 64'd0), opc, 0,
             pc + {im[61:0], 2'b00});
      apply(v, $sformatf("rnd%0d", i));
    end

    // Mid-stream reset: outputs nonzero, then reset drops between edges.
    v = mk(1, 2'b10, OP_BAD, 0, 64'd1, 64'd1, 64'd1, 64'h100, 64'd0, 1, 4'b1111, 1, 64'h104);
    apply(v, "pre_reset");
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    @(posedge clock); #1 chk_all_zero("reset_hold2");
    // Deassert with a vector already applied; it is captured on the next edge.
    @(negedge clock);
    v = mk(1, 2'b10, OP_ADD, 0, 64'd20, 64'd22, 64'd0, 64'h10, 64'd42, 0, 4'b0010, 0, 64'h10);
    drive(v);
    #1 reset = 1'b1;
    #1 chk_all_zero("no_capture_yet");
    @(posedge clock); #1;
    chk("first_capture.out_valid", {63'd0, out_valid}, 64'd1);
    chk("first_capture.result", alu_result, 64'd42);

`ifdef ALU_FLAGS_EN
    v = mk(1, 2'b10, OP_ADD, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
           64'h8000_0000_0000_0000, 0, 4'b0010, 0, 64'd0);
    apply(v, "flags_ovf");
    chk("flags_ovf.overflow", {63'd0, overflow}, 64'd1);
    chk("flags_ovf.carry",    {63'd0, carry},    64'd0);
    v = mk(1, 2'b10, OP_SUB, 0, 64'd5, 64'd3, 64'd0, 64'd0, 64'd2, 0, 4'b0110, 0, 64'd0);
    apply(v, "flags_sub");
    chk("flags_sub.carry",    {63'd0, carry},    64'd1);
    chk("flags_sub.overflow", {63'd0, overflow}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
